mem_arbiter: RTL and testbench

Shares the single main-memory port (t_command/t_addr/t_data out, r_response/r_data/r_tag in) among N_REQ requesters: instruction cache, data cache, and victim-cache writeback. Round-robin arbitration selects one command per cycle. A tag-ownership table routes each returned load block to the requester that issued it. The block sits between the cache hierarchy and the memory model.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single main-memory port among N_REQ requesters,
// with a tag-ownership table that steers returned load blocks back to their issuer.
module mem_arbiter #(
    parameter int N_REQ    = 3,
    parameter int NUM_TAGS = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_REQ-1:0][1:0]                req_command,
    input  logic [N_REQ-1:0][31:0]               req_addr,
    input  logic [N_REQ-1:0][63:0]               req_data,
    output logic [N_REQ-1:0][$clog2(NUM_TAGS)-1:0] req_response,
    output logic [N_REQ-1:0]                     resp_valid,
    output logic [63:0]                          resp_data,
    output logic [$clog2(NUM_TAGS)-1:0]          resp_tag,
    output logic                                 stray_tag,
    output logic [1:0]                           t_command,
    output logic [31:0]                          t_addr,
    output logic [63:0]                          t_data,
    input  logic [$clog2(NUM_TAGS)-1:0]          r_response,
    input  logic [63:0]                          r_data,
    input  logic [$clog2(NUM_TAGS)-1:0]          r_tag
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TAG_W = $clog2(NUM_TAGS);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } mem_cmd_e;

    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_TAGS-1:0]              pending_q, pending_d;
    logic [NUM_TAGS-1:0][IDX_W-1:0]   owner_q, owner_d;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic             accept;
    logic             ret_hit;

    // NOTE: every signal written here gets a default before any branch, so no latch can be inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int unsigned cand;
            cand = (int'(rr_ptr_q) + i) % N_REQ;
            if (!found && req_command[cand] != CMD_NONE) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        t_command    = CMD_NONE;
        t_addr       = '0;
        t_data       = '0;
        req_response = '0;
        if (found) begin
            t_command            = req_command[winner];
            t_addr               = req_addr[winner];
            t_data               = req_data[winner];
            req_response[winner] = r_response;
        end
    end

    // Return routing reads only registered state; a load never completes in its accept cycle.
    assign ret_hit = (r_tag != '0) && pending_q[r_tag];

    always_comb begin
        resp_valid = '0;
        if (ret_hit)
            resp_valid[owner_q[r_tag]] = 1'b1;
    end

    assign stray_tag = (r_tag != '0) && !pending_q[r_tag];
    assign resp_data = (r_tag != '0) ? r_data : '0;
    assign resp_tag  = r_tag;
    assign accept    = found && (r_response != '0);

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q;
        owner_d   = owner_q;
        if (ret_hit)
            pending_d[r_tag] = 1'b0;
        // Set after clear: a tag reissued in its own return cycle stays pending for the new owner.
        if (accept) begin
            rr_ptr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            if (req_command[winner] == CMD_LOAD) begin
                pending_d[r_response] = 1'b1;
                owner_d[r_response]   = winner;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: the tag table is cleared on reset because in-flight loads must be forgotten, not merely ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            pending_q <= '0;
            owner_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            owner_q   <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for same-cycle tag reuse and mid-flight reset.
module tb_mem_arbiter;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam int         NO_WIN = 3;

    logic                 clock;
    logic                 reset;
    logic [2:0][1:0]      req_command;
    logic [2:0][31:0]     req_addr;
    logic [2:0][63:0]     req_data;
    logic [2:0][3:0]      req_response;
    logic [2:0]           resp_valid;
    logic [63:0]          resp_data;
    logic [3:0]           resp_tag;
    logic                 stray_tag;
    logic [1:0]           t_command;
    logic [31:0]          t_addr;
    logic [63:0]          t_data;
    logic [3:0]           r_response;
    logic [63:0]          r_data;
    logic [3:0]           r_tag;

    logic [31:0] addr_c [3];
    logic [63:0] data_c [3];

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.N_REQ(3), .NUM_TAGS(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_command  (req_command),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_response (req_response),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag),
        .stray_tag    (stray_tag),
        .t_command    (t_command),
        .t_addr       (t_addr),
        .t_data       (t_data),
        .r_response   (r_response),
        .r_data       (r_data),
        .r_tag        (r_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic            rst;
        logic [2:0][1:0] cmd;
        logic [3:0]      rresp;
        logic [3:0]      rtag;
        logic [63:0]     rdata;
        int              win;
        logic [2:0]      valid;
        logic            stray;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] c0, input logic [1:0] c1,
                                input logic [1:0] c2, input logic [3:0] rresp, input logic [3:0] rtag,
                                input logic [63:0] rdata, input int win, input logic [2:0] valid,
                                input logic stray);
        vec_t v;
        v.rst   = rst;
        v.cmd   = {c2, c1, c0};
        v.rresp = rresp;
        v.rtag  = rtag;
        v.rdata = rdata;
        v.win   = win;
        v.valid = valid;
        v.stray = stray;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0][1:0] cmd, input logic [3:0] rresp,
                         input logic [3:0] rtag, input logic [63:0] rdata);
        @(negedge clock);
        reset       = rst;
        req_command = cmd;
        r_response  = rresp;
        r_tag       = rtag;
        r_data      = rdata;
        #2;
    endtask

    // Compare every output against the arbitration rules for the expected winner.
    task automatic check_all(input string tag, input vec_t v);
        logic [1:0]      e_cmd;
        logic [31:0]     e_addr;
        logic [63:0]     e_data;
        logic [2:0][3:0] e_grant;
        e_cmd   = N;
        e_addr  = '0;
        e_data  = '0;
        e_grant = '0;
        if (v.win != NO_WIN) begin
            e_cmd          = v.cmd[v.win];
            e_addr         = addr_c[v.win];
            e_data         = data_c[v.win];
            e_grant[v.win] = v.rresp;
        end
        check({tag, "_tcmd"},  64'(t_command),    64'(e_cmd));
        check({tag, "_taddr"}, 64'(t_addr),       64'(e_addr));
        check({tag, "_tdata"}, t_data,            e_data);
        check({tag, "_grant"}, 64'(req_response), 64'(e_grant));
        check({tag, "_valid"}, 64'(resp_valid),   64'(v.valid));
        check({tag, "_stray"}, 64'(stray_tag),    64'(v.stray));
        check({tag, "_rdata"}, resp_data,         (v.rtag != 0) ? v.rdata : 64'd0);
        check({tag, "_rtag"},  64'(resp_tag),     64'(v.rtag));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        drive(v.rst, v.cmd, v.rresp, v.rtag, v.rdata);
        check_all(tag, v);
    endtask

    initial begin
        addr_c[0] = 32'h0000_0040;
        addr_c[1] = 32'h0000_0100;
        addr_c[2] = 32'h0000_02C0;
        data_c[0] = 64'h1111_0000_0000_0001;
        data_c[1] = 64'h2222_0000_0000_0002;
        data_c[2] = 64'h3333_0000_0000_0003;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = addr_c[i];
            req_data[i] = data_c[i];
        end
        reset       = 1'b1;
        req_command = '0;
        r_response  = '0;
        r_tag       = '0;
        r_data      = '0;

        // reset and idle
        vecs.push_back(mk(1, N, N, N, 0, 0, 64'h0, NO_WIN, 3'b000, 0));
        vecs.push_back(mk(0, N, N, N, 0, 0, 64'h0, NO_WIN, 3'b000, 0));
        // fairness: three loads granted 0,1,2 with tags 1,2,3
        vecs.push_back(mk(0, L, L, L, 1, 0, 64'h0, 0, 3'b000, 0));
        vecs.push_back(mk(0, N, L, L, 2, 0, 64'h0, 1, 3'b000, 0));
        vecs.push_back(mk(0, N, N, L, 3, 0, 64'h0, 2, 3'b000, 0));
        vecs.push_back(mk(0, N, N, N, 0, 2, 64'hDEAD_BEEF, NO_WIN, 3'b010, 0));
        vecs.push_back(mk(0, N, N, N, 0, 2, 64'hABCD, NO_WIN, 3'b000, 1));
        vecs.push_back(mk(0, N, N, N, 0, 1, 64'h5555, NO_WIN, 3'b001, 0));
        // rejection hold: store from requester 1 rejected three times, then tag 5
        vecs.push_back(mk(0, N, S, N, 0, 0, 64'h0, 1, 3'b000, 0));
        vecs.push_back(mk(0, N, S, N, 0, 0, 64'h0, 1, 3'b000, 0));
        vecs.push_back(mk(0, N, S, N, 0, 0, 64'h0, 1, 3'b000, 0));
        vecs.push_back(mk(0, N, S, N, 5, 0, 64'h0, 1, 3'b000, 0));
        // store left nothing pending; remaining load tag 3 belongs to requester 2
        vecs.push_back(mk(0, N, N, N, 0, 5, 64'h7777, NO_WIN, 3'b000, 1));
        vecs.push_back(mk(0, N, N, N, 0, 3, 64'h3030, NO_WIN, 3'b100, 0));
        vecs.push_back(mk(0, N, N, N, 0, 7, 64'h0707, NO_WIN, 3'b000, 1));
        vecs.push_back(mk(0, N, N, N, 0, 0, 64'h0707, NO_WIN, 3'b000, 0));
        // rr_ptr is 2: wrap-around to 0 after requester 2 is accepted
        vecs.push_back(mk(0, L, L, L, 0, 0, 64'h0, 2, 3'b000, 0));
        vecs.push_back(mk(0, L, L, L, 6, 0, 64'h0, 2, 3'b000, 0));
        vecs.push_back(mk(0, L, L, L, 0, 0, 64'h0, 0, 3'b000, 0));
        vecs.push_back(mk(0, N, N, N, 0, 6, 64'h6060, NO_WIN, 3'b100, 0));
        // skip an idle requester and wrap the scan
        vecs.push_back(mk(0, L, N, N, 8, 0, 64'h0, 0, 3'b000, 0));
        vecs.push_back(mk(0, L, N, S, 0, 0, 64'h0, 2, 3'b000, 0));
        vecs.push_back(mk(0, L, N, N, 0, 0, 64'h0, 0, 3'b000, 0));
        vecs.push_back(mk(0, N, N, N, 0, 8, 64'h8080, NO_WIN, 3'b001, 0));

        foreach (vecs[i])
            run_vec($sformatf("v%0d", i), vecs[i]);

        // same-cycle tag reuse: rr_ptr is 1, requester 0 takes tag 4
        drive(0, {N, N, L}, 4'd4, 4'd0, 64'h0);
        check("reuse_grant0", 64'(req_response), 64'({4'd0, 4'd0, 4'd4}));
        drive(0, {L, N, N}, 4'd4, 4'd4, 64'h4444);
        check("reuse_grant2", 64'(req_response), 64'({4'd4, 4'd0, 4'd0}));
        check("reuse_old_owner", 64'(resp_valid), 64'(3'b001));
        check("reuse_data", resp_data, 64'h4444);
        check("reuse_stray", 64'(stray_tag), 64'd0);
        drive(0, {N, N, N}, 4'd0, 4'd4, 64'h4545);
        check("reuse_new_owner", 64'(resp_valid), 64'(3'b100));
        check("reuse_new_stray", 64'(stray_tag), 64'd0);

        // reset mid-flight: rr_ptr is 0, tags 1 and 2 pending, then reset
        drive(0, {N, N, L}, 4'd1, 4'd0, 64'h0);
        check("mid_grant0", 64'(req_response), 64'({4'd0, 4'd0, 4'd1}));
        drive(0, {N, L, N}, 4'd2, 4'd0, 64'h0);
        check("mid_grant1", 64'(req_response), 64'({4'd0, 4'd2, 4'd0}));
        drive(1, {N, N, N}, 4'd0, 4'd0, 64'h0);
        check("mid_rst_tcmd", 64'(t_command), 64'(N));
        drive(0, {L, L, L}, 4'd0, 4'd1, 64'h1010);
        check("mid_stray", 64'(stray_tag), 64'd1);
        check("mid_valid", 64'(resp_valid), 64'd0);
        check("mid_winner_addr", 64'(t_addr), 64'(addr_c[0]));
        drive(0, {L, L, L}, 4'd9, 4'd2, 64'h2020);
        check("mid_first_grant", 64'(req_response), 64'({4'd0, 4'd0, 4'd9}));
        check("mid_stray2", 64'(stray_tag), 64'd1);
        check("mid_valid2", 64'(resp_valid), 64'd0);

        drive(0, {N, N, N}, 4'd0, 4'd0, 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
